// File: rtl/ball_ctrl.sv
// ball_ctrl: per-frame ball motion stage downstream of collision_ctrl.
// Collision levels are latched during the active frame. Once per frame, on the
// rising edge of vsync, the ball is moved, reflected off the walls, parked on
// the paddle, or frozen after a win/lose.
//
// Ports:
//   pxl_clk      pixel clock, all logic on the rising edge
//   reset_n      asynchronous active-low reset
//   vsync        1 = vertical blanking, 0 = active frame
//   start        new game; returns to IDLE with the ball parked
//   launch       player launch request, sampled on the frame tick in IDLE
//   paddle_x     paddle centre column
//   h_collision  horizontal bounce request from collision_ctrl
//   v_collision  vertical bounce request from collision_ctrl
//   win, lose    end-of-game flags from collision_ctrl
//   ball_x/y     registered ball centre
//   dir_left     1 = moving toward decreasing x
//   dir_up       1 = moving toward decreasing y
//   frame_tick   one-cycle pulse on the frame update edge
//   running      1 while in RUN
module ball_ctrl #(
  parameter logic [9:0] X_MIN   = 10'd8,
  parameter logic [9:0] X_MAX   = 10'd631,
  parameter logic [9:0] Y_MIN   = 10'd8,
  parameter logic [9:0] BALL_R  = 10'd5,
  parameter logic [9:0] STEP    = 10'd2,
  parameter logic [9:0] START_Y = 10'd440,
  parameter logic [9:0] X_RESET = 10'd320
) (
  input  logic       pxl_clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       start,
  input  logic       launch,
  input  logic [9:0] paddle_x,
  input  logic       h_collision,
  input  logic       v_collision,
  input  logic       win,
  input  logic       lose,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       dir_left,
  output logic       dir_up,
  output logic       frame_tick,
  output logic       running
);

  localparam logic [9:0] X_LO    = X_MIN + BALL_R;
  localparam logic [9:0] X_HI    = X_MAX - BALL_R;
  localparam logic [9:0] Y_LO    = Y_MIN + BALL_R;
  localparam logic [9:0] X_LO_TH = X_LO + STEP;
  localparam logic [9:0] Y_LO_TH = Y_LO + STEP;
  localparam logic [9:0] Y_HI_TH = 10'd1023 - STEP;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e     state_q;
  logic       vsync_q;
  logic       h_hit_q, v_hit_q;
  logic       tick;
  logic       d, u;
  logic [9:0] nx, ny;
  logic       nl, nu;

  function automatic logic [9:0] clamp_x(input logic [9:0] x);
    if (x < X_LO)      return X_LO;
    else if (x > X_HI) return X_HI;
    else               return x;
  endfunction

  assign tick = vsync & ~vsync_q;

  // Motion update: hit flips are applied before the wall rules, so a wall
  // clamp always sees the post-hit direction.
  always_comb begin
    d  = dir_left ^ h_hit_q;
    u  = dir_up ^ v_hit_q;
    nx = ball_x;
    nl = d;
    ny = ball_y;
    nu = u;
    if (d && (ball_x < X_LO_TH)) begin
      nx = X_LO;
      nl = 1'b0;
    end else if (!d && (ball_x + STEP > X_HI)) begin
      nx = X_HI;
      nl = 1'b1;
    end else if (d) begin
      nx = ball_x - STEP;
    end else begin
      nx = ball_x + STEP;
    end
    if (u && (ball_y < Y_LO_TH)) begin
      ny = Y_LO;
      nu = 1'b0;
    end else if (!u && (ball_y > Y_HI_TH)) begin
      ny = ball_y;  // saturate at the bottom instead of wrapping
      nu = 1'b0;
    end else if (u) begin
      ny = ball_y - STEP;
    end else begin
      ny = ball_y + STEP;
    end
  end

  always_ff @(posedge pxl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      vsync_q    <= 1'b0;
      h_hit_q    <= 1'b0;
      v_hit_q    <= 1'b0;
      ball_x     <= X_RESET;
      ball_y     <= START_Y;
      dir_left   <= 1'b0;
      dir_up     <= 1'b1;
      frame_tick <= 1'b0;
      running    <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= tick;
      // Collisions during blanking are ignored; tick implies vsync=1, so the
      // clear and set terms never overlap.
      if (start || tick) begin
        h_hit_q <= 1'b0;
        v_hit_q <= 1'b0;
      end else begin
        h_hit_q <= h_hit_q | (h_collision & ~vsync);
        v_hit_q <= v_hit_q | (v_collision & ~vsync);
      end

      if (start) begin
        state_q  <= StIdle;
        running  <= 1'b0;
        ball_x   <= clamp_x(paddle_x);
        ball_y   <= START_Y;
        dir_left <= 1'b0;
        dir_up   <= 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            if (tick) begin
              ball_x   <= clamp_x(paddle_x);
              ball_y   <= START_Y;
              dir_left <= 1'b0;
              dir_up   <= 1'b1;
              if (launch) begin
                state_q <= StRun;
                running <= 1'b1;
              end
            end
          end
          StRun: begin
            if (win || lose) begin
              state_q <= StHalt;
              running <= 1'b0;
            end else if (tick) begin
              ball_x   <= nx;
              ball_y   <= ny;
              dir_left <= nl;
              dir_up   <= nu;
            end
          end
          StHalt: begin
          end
          default: begin
            state_q <= StIdle;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_ctrl.sv
module tb_ball_ctrl;

  logic       pxl_clk = 1'b0;
  logic       reset_n;
  logic       vsync, start, launch, h_collision, v_collision, win, lose;
  logic [9:0] paddle_x;
  logic [9:0] ball_x, ball_y;
  logic       dir_left, dir_up, frame_tick, running;

  int total = 0;
  int bad   = 0;

  always #5 pxl_clk = ~pxl_clk;

  ball_ctrl dut (
    .pxl_clk    (pxl_clk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .start      (start),
    .launch     (launch),
    .paddle_x   (paddle_x),
    .h_collision(h_collision),
    .v_collision(v_collision),
    .win        (win),
    .lose       (lose),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .dir_left   (dir_left),
    .dir_up     (dir_up),
    .frame_tick (frame_tick),
    .running    (running)
  );

  // One frame: 4 active cycles with the collision inputs held for the first
  // hc/vc cycles, then vsync rises. Returns one negedge after the tick edge.
  task automatic frame(input int hc, input int vc);
    vsync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      h_collision = (i < hc);
      v_collision = (i < vc);
      @(negedge pxl_clk);
    end
    h_collision = 1'b0;
    v_collision = 1'b0;
    vsync = 1'b1;
    @(negedge pxl_clk);
  endtask

  task automatic do_start(input logic [9:0] px);
    paddle_x = px;
    start = 1'b1;
    @(negedge pxl_clk);
    start = 1'b0;
  endtask

  task automatic launch_frame();
    launch = 1'b1;
    frame(0, 0);
    launch = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; vsync = 1'b0; start = 1'b0; launch = 1'b0; paddle_x = 10'd0;
    h_collision = 1'b0; v_collision = 1'b0; win = 1'b0; lose = 1'b0;
    #12;
    total++; if (ball_x !== 10'd320) begin bad++; $display("FAIL rst_x got=%0d want=320", ball_x); end
    total++; if (ball_y !== 10'd440) begin bad++; $display("FAIL rst_y got=%0d want=440", ball_y); end
    total++; if ({dir_left, dir_up, running, frame_tick} !== 4'b0100) begin
      bad++; $display("FAIL rst_flags got=%b want=0100", {dir_left, dir_up, running, frame_tick});
    end
    @(negedge pxl_clk);
    reset_n = 1'b1;
    repeat (3) @(negedge pxl_clk);
    total++; if ({ball_x, ball_y} !== {10'd320, 10'd440}) begin
      bad++; $display("FAIL rel_pos got=%0d,%0d want=320,440", ball_x, ball_y);
    end
    total++; if ({dir_left, dir_up, running, frame_tick} !== 4'b0100) begin
      bad++; $display("FAIL rel_flags got=%b want=0100", {dir_left, dir_up, running, frame_tick});
    end
  endtask

  task automatic test_launch();
    paddle_x = 10'd2;
    frame(0, 0);
    total++; if (ball_x !== 10'd13) begin bad++; $display("FAIL clamp_lo got=%0d want=13", ball_x); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL idle_run got=%b want=0", running); end
    paddle_x = 10'd700;
    frame(0, 0);
    total++; if (ball_x !== 10'd626) begin bad++; $display("FAIL clamp_hi got=%0d want=626", ball_x); end
    paddle_x = 10'd100;
    launch_frame();
    total++; if ({ball_x, ball_y} !== {10'd100, 10'd440}) begin
      bad++; $display("FAIL launch_pos got=%0d,%0d want=100,440", ball_x, ball_y);
    end
    total++; if ({running, frame_tick} !== 2'b11) begin
      bad++; $display("FAIL launch_run_tick got=%b want=11", {running, frame_tick});
    end
    @(negedge pxl_clk);
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL tick_width got=%b want=0", frame_tick); end
    frame(0, 0);
    total++; if ({ball_x, ball_y} !== {10'd102, 10'd438}) begin
      bad++; $display("FAIL first_move got=%0d,%0d want=102,438", ball_x, ball_y);
    end
    total++; if ({dir_left, dir_up} !== 2'b01) begin
      bad++; $display("FAIL first_dir got=%b want=01", {dir_left, dir_up});
    end
  endtask

  task automatic test_vhit();
    do_start(10'd300);
    launch_frame();
    for (int i = 0; i < 120; i++) frame(0, 0);
    total++; if ({ball_x, ball_y} !== {10'd540, 10'd200}) begin
      bad++; $display("FAIL pre_vhit got=%0d,%0d want=540,200", ball_x, ball_y);
    end
    frame(0, 3);
    total++; if ({ball_x, ball_y, dir_up} !== {10'd542, 10'd202, 1'b0}) begin
      bad++; $display("FAIL vhit got=%0d,%0d,%b want=542,202,0", ball_x, ball_y, dir_up);
    end
    frame(0, 0);
    total++; if ({ball_y, dir_up} !== {10'd204, 1'b0}) begin
      bad++; $display("FAIL vhit_clear got=%0d,%b want=204,0", ball_y, dir_up);
    end
    // Collision during blanking must be ignored.
    v_collision = 1'b1;
    repeat (2) @(negedge pxl_clk);
    v_collision = 1'b0;
    frame(0, 0);
    total++; if ({ball_y, dir_up} !== {10'd206, 1'b0}) begin
      bad++; $display("FAIL vblank_ignore got=%0d,%b want=206,0", ball_y, dir_up);
    end
  endtask

  task automatic test_walls();
    do_start(10'd14);
    total++; if (ball_x !== 10'd14) begin bad++; $display("FAIL start_x got=%0d want=14", ball_x); end
    launch_frame();
    frame(1, 0);
    total++; if ({ball_x, ball_y, dir_left} !== {10'd13, 10'd438, 1'b0}) begin
      bad++; $display("FAIL left_wall got=%0d,%0d,%b want=13,438,0", ball_x, ball_y, dir_left);
    end
    frame(0, 0);
    total++; if (ball_x !== 10'd15) begin bad++; $display("FAIL left_after got=%0d want=15", ball_x); end
    do_start(10'd625);
    launch_frame();
    frame(0, 0);
    total++; if ({ball_x, ball_y, dir_left} !== {10'd626, 10'd438, 1'b1}) begin
      bad++; $display("FAIL right_wall got=%0d,%0d,%b want=626,438,1", ball_x, ball_y, dir_left);
    end
    frame(0, 0);
    total++; if ({ball_x, dir_left} !== {10'd624, 1'b1}) begin
      bad++; $display("FAIL right_after got=%0d,%b want=624,1", ball_x, dir_left);
    end
    frame(2, 2);
    total++; if ({ball_x, ball_y, dir_left, dir_up} !== {10'd626, 10'd438, 2'b00}) begin
      bad++; $display("FAIL both_hits got=%0d,%0d,%b%b want=626,438,00",
                      ball_x, ball_y, dir_left, dir_up);
    end
  endtask

  task automatic test_vertical_limits();
    do_start(10'd320);
    launch_frame();
    for (int i = 0; i < 213; i++) frame(0, 0);
    total++; if ({ball_y, dir_up} !== {10'd14, 1'b1}) begin
      bad++; $display("FAIL top_pre got=%0d,%b want=14,1", ball_y, dir_up);
    end
    frame(0, 0);
    total++; if ({ball_y, dir_up} !== {10'd13, 1'b0}) begin
      bad++; $display("FAIL top_wall got=%0d,%b want=13,0", ball_y, dir_up);
    end
    frame(0, 0);
    total++; if (ball_y !== 10'd15) begin bad++; $display("FAIL top_after got=%0d want=15", ball_y); end
    for (int i = 0; i < 503; i++) frame(0, 0);
    total++; if (ball_y !== 10'd1021) begin bad++; $display("FAIL bot_pre got=%0d want=1021", ball_y); end
    frame(0, 0);
    total++; if (ball_y !== 10'd1023) begin bad++; $display("FAIL bot_step got=%0d want=1023", ball_y); end
    frame(0, 0);
    total++; if ({ball_y, dir_up} !== {10'd1023, 1'b0}) begin
      bad++; $display("FAIL bot_sat got=%0d,%b want=1023,0", ball_y, dir_up);
    end
  endtask

  task automatic test_halt();
    do_start(10'd200);
    launch_frame();
    frame(0, 0);
    // win coinciding with the tick edge: no position update.
    vsync = 1'b0;
    repeat (4) @(negedge pxl_clk);
    vsync = 1'b1; win = 1'b1;
    @(negedge pxl_clk);
    win = 1'b0;
    total++; if ({ball_x, ball_y, running} !== {10'd202, 10'd438, 1'b0}) begin
      bad++; $display("FAIL win_tick got=%0d,%0d,%b want=202,438,0", ball_x, ball_y, running);
    end
    do_start(10'd50);
    total++; if ({ball_x, ball_y, dir_left, dir_up, running} !== {10'd50, 10'd440, 3'b010}) begin
      bad++; $display("FAIL restart got=%0d,%0d,%b want=50,440,010", ball_x, ball_y,
                      {dir_left, dir_up, running});
    end
    launch_frame();
    frame(0, 0);
    vsync = 1'b0;
    @(negedge pxl_clk);
    lose = 1'b1;
    @(negedge pxl_clk);
    lose = 1'b0;
    @(negedge pxl_clk);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL lose_run got=%b want=0", running); end
    for (int i = 0; i < 3; i++) begin
      frame(1, 1);
      total++; if ({ball_x, ball_y, dir_left, dir_up} !== {10'd52, 10'd438, 2'b01}) begin
        bad++; $display("FAIL halt_hold%0d got=%0d,%0d,%b%b want=52,438,01", i, ball_x, ball_y,
                        dir_left, dir_up);
      end
    end
    do_start(10'd700);
    total++; if ({ball_x, ball_y, running} !== {10'd626, 10'd440, 1'b0}) begin
      bad++; $display("FAIL halt_start got=%0d,%0d,%b want=626,440,0", ball_x, ball_y, running);
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_vhit();
    test_walls();
    test_vertical_limits();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
